// File: rtl/switch_conditioner.sv
// Synchronises and debounces the board switches and the hold pushbutton for the LED hold register.
// Optional feature: define RETAIN_TOGGLE_EN for press-to-hold/press-to-release retain; otherwise retain follows the button.
module switch_conditioner #(
  parameter int N               = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] sw_raw,
  input  logic         btn_raw,
  output logic [N-1:0] sw_out,
  output logic         sw_changed,
  output logic         retain,
  output logic         busy
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic {IDLE, COUNT} state_t;

  logic [N-1:0]           sw_sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] btn_sync_q;
  logic [N-1:0]           sw_sync;
  logic                   btn_sync;

  // NOTE: the synchroniser array is explicitly cleared in reset, so no stale pre-reset pin
  // sample can leak into the debouncer after reset is released.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sw_sync_q[i] <= '0;
      btn_sync_q <= '0;
    end else begin
      sw_sync_q[0] <= sw_raw;
      for (int i = 1; i < SYNC_STAGES; i++) sw_sync_q[i] <= sw_sync_q[i-1];
      btn_sync_q <= {btn_sync_q[SYNC_STAGES-2:0], btn_raw};
    end
  end

  assign sw_sync  = sw_sync_q[SYNC_STAGES-1];
  assign btn_sync = btn_sync_q[SYNC_STAGES-1];

  state_t        state, state_d;
  logic [N-1:0]  candidate, candidate_d, sw_out_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          sw_changed_d;

  // NOTE: every next-state value gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d      = state;
    candidate_d  = candidate;
    cnt_d        = cnt;
    sw_out_d     = sw_out;
    sw_changed_d = 1'b0;
    case (state)
      IDLE: begin
        if (sw_sync != sw_out) begin
          candidate_d = sw_sync;
          cnt_d       = CNT_ONE;
          state_d     = COUNT;
        end
      end
      COUNT: begin
        if (sw_sync == sw_out) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (sw_sync != candidate) begin
          candidate_d = sw_sync;
          cnt_d       = CNT_ONE;
        end else if (cnt == CNT_MAX) begin
          sw_out_d     = candidate;
          sw_changed_d = 1'b1;
          cnt_d        = '0;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      candidate  <= '0;
      cnt        <= '0;
      sw_out     <= '0;
      sw_changed <= 1'b0;
    end else begin
      state      <= state_d;
      candidate  <= candidate_d;
      cnt        <= cnt_d;
      sw_out     <= sw_out_d;
      sw_changed <= sw_changed_d;
    end
  end

  assign busy = (state == COUNT);

  // Single-bit debouncer: a zero count plays the role of IDLE, and the candidate is always ~btn_stable.
  logic [CW-1:0] btn_cnt;
  logic          btn_stable;

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_cnt    <= '0;
      btn_stable <= 1'b0;
    end else if (btn_sync == btn_stable) begin
      btn_cnt <= '0;
    end else if (btn_cnt == CNT_MAX) begin
      btn_stable <= btn_sync;
      btn_cnt    <= '0;
    end else begin
      btn_cnt <= btn_cnt + CNT_ONE;
    end
  end

`ifdef RETAIN_TOGGLE_EN
  logic retain_q;
  logic btn_press;

  // Rising edge detected at the moment btn_stable is accepted high, so retain moves in the same cycle.
  assign btn_press = (btn_sync != btn_stable) && (btn_cnt == CNT_MAX) && btn_sync;

  always_ff @(posedge clk) begin
    if (reset)          retain_q <= 1'b0;
    else if (btn_press) retain_q <= ~retain_q;
  end

  assign retain = retain_q;
`else
  assign retain = btn_stable;
`endif

endmodule

// File: tb/tb_switch_conditioner.sv
// Self-checking bench for switch_conditioner (N=16, SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Expected sw_out updates are queued when stimulus is driven and matched against sw_changed pulses.
module tb_switch_conditioner;

  localparam int N    = 16;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int LAT  = SYNC + DEB;
`ifdef RETAIN_TOGGLE_EN
  localparam bit TOGGLE = 1'b1;
`else
  localparam bit TOGGLE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] sw_raw;
  logic         btn_raw;
  logic [N-1:0] sw_out;
  logic         sw_changed;
  logic         retain;
  logic         busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int           due;
    logic [N-1:0] val;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  switch_conditioner #(
    .N              (N),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sw_raw    (sw_raw),
    .btn_raw   (btn_raw),
    .sw_out    (sw_out),
    .sw_changed(sw_changed),
    .retain    (retain),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    if (obs !== want) begin
      failures++;
      $display("FAIL %s obs=%0h want=%0h (cycle %0d)", tag, obs, want, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_sw(input logic [N-1:0] v);
    exp_t e;
    e.due = cyc + LAT;
    e.val = v;
    exp_q.push_back(e);
  endtask

  // Scoreboard: each queued update must appear exactly at its due cycle; any other pulse is spurious.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0 && cyc >= exp_q[0].due) begin
      mon_e = exp_q.pop_front();
      check("sw_changed_at_due", {31'd0, sw_changed}, 32'd1);
      check("sw_out_at_due", {16'd0, sw_out}, {16'd0, mon_e.val});
    end else if (sw_changed) begin
      check("sw_changed_unexpected", {31'd0, sw_changed}, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    sw_raw  = '1;
    btn_raw = 1'b0;

    // Reset held with all switches high
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_sw_out", {16'd0, sw_out}, 32'd0);
      check("rst_retain", {31'd0, retain}, 32'd0);
      check("rst_changed", {31'd0, sw_changed}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
    end
    sw_raw = '0;
    reset  = 1'b0;
    tick(3);
    check("idle_sw_out", {16'd0, sw_out}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Clean change: busy for the three cycles before the update
    sw_raw = 16'hA5A5;
    expect_sw(16'hA5A5);
    for (int i = 1; i <= LAT; i++) begin
      tick();
      check("clean_busy", {31'd0, busy}, {31'd0, (i >= SYNC + 1 && i < LAT)});
    end
    tick(2);
    check("clean_sw_out", {16'd0, sw_out}, 32'h0000_A5A5);

    sw_raw = '0;
    expect_sw('0);
    tick(LAT + 2);

    // Bounce on bit 0, finally settling high
    for (int i = 0; i < 10; i++) begin
      sw_raw = N'(i % 2);
      if (i == 9) expect_sw(16'h0001);
      tick();
    end
    tick(LAT + 2);
    check("bounce_sw_out", {16'd0, sw_out}, 32'h0000_0001);

    sw_raw = '0;
    expect_sw('0);
    tick(LAT + 2);

    // Two-cycle glitch must be rejected
    sw_raw = 16'h0010;
    tick(2);
    sw_raw = '0;
    tick();
    check("glitch_busy", {31'd0, busy}, 32'd1);
    tick(LAT + 2);
    check("glitch_sw_out", {16'd0, sw_out}, 32'd0);
    check("glitch_busy_idle", {31'd0, busy}, 32'd0);

    // Retain: press, release, press again (with a simultaneous switch change)
    btn_raw = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("press1_retain", {31'd0, retain}, {31'd0, (i >= LAT)});
    end
    btn_raw = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("release1_retain", {31'd0, retain}, {31'd0, (TOGGLE ? 1'b1 : (i < LAT))});
    end
    btn_raw = 1'b1;
    sw_raw  = 16'h3C3C;
    expect_sw(16'h3C3C);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("press2_retain", {31'd0, retain}, {31'd0, (TOGGLE ? (i < LAT) : (i >= LAT))});
    end
    btn_raw = 1'b0;
    tick(LAT + 2);
    check("release2_retain", {31'd0, retain}, 32'd0);
    check("press2_sw_out", {16'd0, sw_out}, 32'h0000_3C3C);

    // Reset during the second cycle of COUNT abandons the change
    sw_raw = 16'h00FF;
    tick(SYNC + 1);
    check("midcnt_busy1", {31'd0, busy}, 32'd1);
    tick();
    check("midcnt_busy2", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    check("midcnt_rst_sw_out", {16'd0, sw_out}, 32'd0);
    check("midcnt_rst_busy", {31'd0, busy}, 32'd0);
    check("midcnt_rst_changed", {31'd0, sw_changed}, 32'd0);
    reset = 1'b0;
    expect_sw(16'h00FF);
    for (int i = 1; i < LAT; i++) begin
      tick();
      check("post_rst_sw_out_hold", {16'd0, sw_out}, 32'd0);
    end
    tick(3);
    check("post_rst_sw_out", {16'd0, sw_out}, 32'h0000_00FF);

    tick(4);
    check("sb_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/switch_conditioner.md
Name: switch_conditioner

Overview:
- Input-conditioning stage that sits directly upstream of the LED hold register.
- Synchronises and debounces the N board switches and a hold pushbutton.
- Produces clean, glitch-free `sw_out` and `retain` signals for the hold register's switch and retain inputs.
- All logic is in the `clk` domain; the raw pins are asynchronous.

Parameters:
- N, 16, number of switch bits.
- SYNC_STAGES, 2, flip-flop depth of each input synchroniser (legal range 2..4).
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required before accepting a change (legal minimum 2).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- sw_raw  input  N  raw asynchronous switch pins.
- btn_raw  input  1  raw asynchronous hold pushbutton, high when pressed.
- sw_out  output  N  debounced switch vector.
- sw_changed  output  1  one-cycle pulse when sw_out updates.
- retain  output  1  hold-request level for the downstream register.
- busy  output  1  high while the switch debouncer is in state COUNT.

Behaviour:
- Reset (synchronous, active-high): applies to every register.
  - All synchroniser flops, sw_out, candidate, counters, sw_changed, retain, busy and btn_stable are cleared to 0.
  - FSM state returns to IDLE.
  - Reset asserted mid-count abandons the pending change; no sw_changed pulse is generated.
- Synchronisers:
  - sw_raw passes through a SYNC_STAGES-deep chain to give sw_sync[N-1:0].
  - btn_raw passes through its own SYNC_STAGES-deep chain to give btn_sync.
- Switch debouncer FSM: states IDLE and COUNT. A single shared counter covers the whole vector; cnt width is $clog2(DEBOUNCE_CYCLES).
  - IDLE, sw_sync != sw_out: candidate <= sw_sync, cnt <= 1, go to COUNT.
  - IDLE, sw_sync == sw_out: stay in IDLE.
  - COUNT, sw_sync == sw_out: bounce-back; go to IDLE, cnt <= 0, no update.
  - COUNT, otherwise sw_sync != candidate: candidate <= sw_sync, cnt <= 1 (restart).
  - COUNT, otherwise cnt == DEBOUNCE_CYCLES-1: sw_out <= candidate, sw_changed <= 1 for exactly one cycle, go to IDLE, cnt <= 0.
  - COUNT, otherwise: cnt <= cnt + 1.
  - Any multi-bit change that is still settling restarts the count; sw_out never presents a partial vector.
- Latency:
  - A clean pin change reaches sw_sync after SYNC_STAGES edges.
  - sw_out then updates on the DEBOUNCE_CYCLES-th consecutive edge at which sw_sync holds the new value.
  - Total is SYNC_STAGES + DEBOUNCE_CYCLES edges.
  - sw_changed is high in the same cycle that the new sw_out is first visible.
- busy equals (state == COUNT).
- Button debouncer:
  - Uses an independent counter with identical accept rules applied to btn_sync, producing btn_stable.
  - No pulse output.
- Retain generation:
  - In toggle mode, a rising edge of btn_stable toggles retain.
  - A falling edge of btn_stable has no effect.
  - The switch and button paths are fully independent; simultaneous events are each handled in the same cycle.
- Counter saturation: cnt never exceeds DEBOUNCE_CYCLES-1, so it never wraps.

Optional Feature:
- Macro: RETAIN_TOGGLE_EN.
- Defined: retain toggles on each debounced press (press-to-hold, press-to-release). Reset value is 0.
- Undefined:
  - retain = btn_stable, so the value is held only while the button is held.
  - The toggle flop and edge detector are not synthesised.
- The switch path is identical in both builds.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, N=16):
1. Reset: hold reset for 3 cycles with sw_raw=16'hFFFF -> sw_out=0, retain=0, sw_changed=0 and busy=0 throughout the reset cycles.
2. Clean change: sw_raw 0 -> 16'hA5A5 and hold -> sw_out=16'hA5A5 exactly 6 edges later; sw_changed high for that single cycle; busy high for the 3 preceding cycles.
3. Bounce: sw_raw toggles bit0 0/1/0/1 every cycle for 10 cycles, then settles to 1 -> no sw_changed during the bounce; sw_out=16'h0001 on the 4th stable sync'd edge after settling.
4. Glitch reject: sw_raw=16'h0010 for 2 cycles, then back to 0 -> sw_out remains 0, no sw_changed, busy returns to 0.
5. Retain: press btn_raw for 8 cycles, release, wait, then press again.
   - With RETAIN_TOGGLE_EN: retain goes 0 -> 1 after 6 edges, stays 1 through the release, returns to 0 on the second press.
   - Without RETAIN_TOGGLE_EN: retain is high only while btn_stable is high.
6. Reset mid-count: sw_raw=16'h00FF, assert reset at the 2nd cycle of COUNT -> sw_out=0, no pulse; after release with sw_raw still 16'h00FF, sw_out=16'h00FF at 6 edges after reset deassertion.
